// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for piso_frame_tx.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface piso_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, sout, bit_valid, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, bit_valid, busy, done
    );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, WIDTH data bits, optional even parity, stop bit.
// Define PISO_FRAME_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module piso_frame_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    piso_frame_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PISO_FRAME_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sout_q, sout_d;
    logic               bit_valid_q, bit_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef PISO_FRAME_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic out_bit;
    logic last_bit;

    assign out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    assign bus.din_ready = (state_q == IDLE);
    assign bus.sout      = sout_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
`ifdef PISO_FRAME_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        sout_d      = 1'b1;
        bit_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    state_d  = START;
                    shreg_d  = bus.din;
`ifdef PISO_FRAME_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            START: state_d = DATA;
            DATA: begin
                if (last_bit) begin
                    cnt_d = '0;
`ifdef PISO_FRAME_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef PISO_FRAME_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state, so the line shows a state's
        // bit in the cycle right after that state is entered.
        case (state_d)
            START: sout_d = 1'b0;
            DATA: begin
                sout_d      = out_bit;
                bit_valid_d = 1'b1;
                shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            end
`ifdef PISO_FRAME_TX_PARITY_EN
            PARITY: sout_d = parity_q;
`endif
            default: sout_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sout_q      <= 1'b1;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_FRAME_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sout_q      <= sout_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PISO_FRAME_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end
endmodule
